// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared widths, RSOP codes and entry type for the reservation station
package rs_pkg;

  localparam int RS_NUM_ENTRIES = 4;
  localparam int RS_TAG_W       = 4;
  localparam int RS_DATA_W      = 32;
  localparam int RS_OP_W        = 5;

  localparam logic [RS_OP_W-1:0] RSOP_AND  = 5'b00000;
  localparam logic [RS_OP_W-1:0] RSOP_OR   = 5'b00001;
  localparam logic [RS_OP_W-1:0] RSOP_ADD  = 5'b00010;
  localparam logic [RS_OP_W-1:0] RSOP_XOR  = 5'b00011;
  localparam logic [RS_OP_W-1:0] RSOP_SLTU = 5'b00100;
  localparam logic [RS_OP_W-1:0] RSOP_NOR  = 5'b00101;
  localparam logic [RS_OP_W-1:0] RSOP_SUB  = 5'b00111;
  localparam logic [RS_OP_W-1:0] RSOP_NOP  = 5'b01000;
  localparam logic [RS_OP_W-1:0] RSOP_BEQ  = 5'b11110;
  localparam logic [RS_OP_W-1:0] RSOP_BNE  = 5'b11111;

  // One station slot at the default widths
  typedef struct packed {
    logic                 valid;
    logic [RS_OP_W-1:0]   op;
    logic [RS_TAG_W-1:0]  dest;
    logic [RS_DATA_W-1:0] vj;
    logic [RS_DATA_W-1:0] vk;
    logic [RS_TAG_W-1:0]  qj;
    logic [RS_TAG_W-1:0]  qk;
    logic                 pj;
    logic                 pk;
  } rs_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] cand;

  // walk the ring starting at ptr; N is a power of two so the index add wraps naturally
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - reservation station with CDB wakeup and RR issue to one ALU (optional RS_PERF_CNT_EN counters)
module rs_issue_scheduler
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES = RS_NUM_ENTRIES,
  parameter int TAG_W       = RS_TAG_W,
  parameter int DATA_W      = RS_DATA_W,
  parameter int OP_W        = RS_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                disp_valid,
  output logic                disp_ready,
  input  logic [OP_W-1:0]     disp_op,
  input  logic [TAG_W-1:0]    disp_dest,
  input  logic [DATA_W-1:0]   disp_vj,
  input  logic [DATA_W-1:0]   disp_vk,
  input  logic [TAG_W-1:0]    disp_qj,
  input  logic [TAG_W-1:0]    disp_qk,
  input  logic                disp_qj_pend,
  input  logic                disp_qk_pend,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [DATA_W-1:0]   cdb_data,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [OP_W-1:0]     issue_op,
  output logic [DATA_W-1:0]   issue_a,
  output logic [DATA_W-1:0]   issue_b,
  output logic [TAG_W-1:0]    issue_dest
`ifdef RS_PERF_CNT_EN
  ,
  output logic [15:0]                    perf_stall_cnt,
  output logic [15:0]                    perf_issue_cnt,
  output logic [$clog2(NUM_ENTRIES):0]   perf_occupancy
`endif
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] ent_valid, ent_pj, ent_pk;
  logic [OP_W-1:0]        ent_op   [NUM_ENTRIES];
  logic [TAG_W-1:0]       ent_dest [NUM_ENTRIES];
  logic [DATA_W-1:0]      ent_vj   [NUM_ENTRIES];
  logic [DATA_W-1:0]      ent_vk   [NUM_ENTRIES];
  logic [TAG_W-1:0]       ent_qj   [NUM_ENTRIES];
  logic [TAG_W-1:0]       ent_qk   [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] ent_ready, grant;
  logic [IDX_W-1:0]       rr_ptr, grant_idx, free_idx;
  logic                   grant_valid, free_any, load, disp_fire, byp_j, byp_k;

  // selection sees only registered pending bits, so a same-cycle wakeup is not yet eligible
  assign ent_ready  = ent_valid & ~ent_pj & ~ent_pk;
  assign load       = ~issue_valid | issue_ready;
  assign disp_ready = free_any;
  assign disp_fire  = disp_valid & free_any;
  assign byp_j      = disp_qj_pend & cdb_valid & (cdb_tag == disp_qj);
  assign byp_k      = disp_qk_pend & cdb_valid & (cdb_tag == disp_qk);

  // lowest-index free slot from registered valid bits; a slot freed this cycle is not offered
  always_comb begin
    free_idx = '0;
    free_any = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_idx = IDX_W'(i);
        free_any = 1'b1;
      end
    end
  end

  rr_arbiter #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_arb (
    .req         (ent_ready),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // entry state: CDB wakeup, release on issue, dispatch write with bypass; flush drops all
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      ent_pj    <= '0;
      ent_pk    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_op[i]   <= '0;
        ent_dest[i] <= '0;
        ent_vj[i]   <= '0;
        ent_vk[i]   <= '0;
        ent_qj[i]   <= '0;
        ent_qk[i]   <= '0;
      end
    end else if (flush) begin
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (ent_valid[i] && ent_pj[i] && cdb_valid && (ent_qj[i] == cdb_tag)) begin
          ent_vj[i] <= cdb_data;
          ent_pj[i] <= 1'b0;
        end
        if (ent_valid[i] && ent_pk[i] && cdb_valid && (ent_qk[i] == cdb_tag)) begin
          ent_vk[i] <= cdb_data;
          ent_pk[i] <= 1'b0;
        end
        if (load && grant[i]) begin
          ent_valid[i] <= 1'b0;
        end
        if (disp_fire && (free_idx == IDX_W'(i))) begin
          ent_valid[i] <= 1'b1;
          ent_op[i]    <= disp_op;
          ent_dest[i]  <= disp_dest;
          ent_qj[i]    <= disp_qj;
          ent_qk[i]    <= disp_qk;
          ent_vj[i]    <= byp_j ? cdb_data : disp_vj;
          ent_vk[i]    <= byp_k ? cdb_data : disp_vk;
          ent_pj[i]    <= disp_qj_pend & ~byp_j;
          ent_pk[i]    <= disp_qk_pend & ~byp_k;
        end
      end
    end
  end

  // issue register: refills whenever empty or being consumed; holds steady under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_op    <= '0;
      issue_a     <= '0;
      issue_b     <= '0;
      issue_dest  <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (load) begin
      issue_valid <= grant_valid;
      if (grant_valid) begin
        issue_op   <= ent_op[grant_idx];
        issue_a    <= ent_vj[grant_idx];
        issue_b    <= ent_vk[grant_idx];
        issue_dest <= ent_dest[grant_idx];
      end
    end
  end

  // round-robin pointer moves just past the entry that was taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (load && grant_valid) begin
      rr_ptr <= grant_idx + 1'b1;
    end
  end

`ifdef RS_PERF_CNT_EN
  // saturating stall and accepted-issue counters; only rst clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_issue_cnt <= '0;
    end else begin
      if (disp_valid && !disp_ready && (perf_stall_cnt != 16'hFFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
      if (issue_valid && issue_ready && (perf_issue_cnt != 16'hFFFF)) begin
        perf_issue_cnt <= perf_issue_cnt + 16'd1;
      end
    end
  end

  // live population count of valid entries
  always_comb begin
    perf_occupancy = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      perf_occupancy = perf_occupancy + (IDX_W + 1)'(ent_valid[i]);
    end
  end
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb/tb_rs_issue_scheduler.sv - scoreboard bench for rs_issue_scheduler against a slot-level reference model
module tb_rs_issue_scheduler;
  import rs_pkg::*;

  localparam int NE = 4;

  logic        clk, rst, flush;
  logic        disp_valid, disp_ready;
  logic [4:0]  disp_op;
  logic [3:0]  disp_dest, disp_qj, disp_qk;
  logic [31:0] disp_vj, disp_vk;
  logic        disp_qj_pend, disp_qk_pend;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_op;
  logic [31:0] issue_a, issue_b;
  logic [3:0]  issue_dest;
`ifdef RS_PERF_CNT_EN
  logic [15:0] perf_stall_cnt, perf_issue_cnt;
  logic [2:0]  perf_occupancy;
`endif

  rs_issue_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_op      (disp_op),
    .disp_dest    (disp_dest),
    .disp_vj      (disp_vj),
    .disp_vk      (disp_vk),
    .disp_qj      (disp_qj),
    .disp_qk      (disp_qk),
    .disp_qj_pend (disp_qj_pend),
    .disp_qk_pend (disp_qk_pend),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_dest   (issue_dest)
`ifdef RS_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_issue_cnt (perf_issue_cnt),
    .perf_occupancy (perf_occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: station as an array of slots, issue register as "loaded, not yet taken"
  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  dest;
  } exp_t;

  rs_entry_t m_ent [NE];
  rs_entry_t nx    [NE];
  exp_t      exp_q [$];
  logic      m_iv;
  int        m_ptr, sel, fr, jj;
  bit        ld;
  int        m_stall, m_issue;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) m_ent[i] = '0;
      m_iv = 1'b0;
      m_ptr = 0;
      m_stall = 0;
      m_issue = 0;
      exp_q.delete();
    end else begin
      fr = -1;
      for (int i = NE - 1; i >= 0; i--) if (!m_ent[i].valid) fr = i;
      if (disp_valid && fr < 0 && m_stall < 65535) m_stall++;
      if (m_iv && issue_ready && m_issue < 65535) m_issue++;
      ld = !m_iv || issue_ready;
      sel = -1;
      if (ld) begin
        for (int k = 0; k < NE; k++) begin
          jj = (m_ptr + k) % NE;
          if (sel < 0 && m_ent[jj].valid && !m_ent[jj].pj && !m_ent[jj].pk) sel = jj;
        end
      end
      if (flush) begin
        if (m_iv && !issue_ready) void'(exp_q.pop_back());
        for (int i = 0; i < NE; i++) m_ent[i].valid = 1'b0;
        m_iv = 1'b0;
        m_ptr = 0;
      end else begin
        nx = m_ent;
        for (int i = 0; i < NE; i++) begin
          if (m_ent[i].valid && m_ent[i].pj && cdb_valid && m_ent[i].qj == cdb_tag) begin
            nx[i].vj = cdb_data;
            nx[i].pj = 1'b0;
          end
          if (m_ent[i].valid && m_ent[i].pk && cdb_valid && m_ent[i].qk == cdb_tag) begin
            nx[i].vk = cdb_data;
            nx[i].pk = 1'b0;
          end
        end
        if (sel >= 0) begin
          nx[sel].valid = 1'b0;
          exp_q.push_back('{m_ent[sel].op, m_ent[sel].vj, m_ent[sel].vk, m_ent[sel].dest});
          m_iv = 1'b1;
          m_ptr = (sel + 1) % NE;
        end else if (ld) begin
          m_iv = 1'b0;
        end
        if (disp_valid && fr >= 0) begin
          nx[fr].valid = 1'b1;
          nx[fr].op    = disp_op;
          nx[fr].dest  = disp_dest;
          nx[fr].qj    = disp_qj;
          nx[fr].qk    = disp_qk;
          nx[fr].pj    = disp_qj_pend && !(cdb_valid && cdb_tag == disp_qj);
          nx[fr].pk    = disp_qk_pend && !(cdb_valid && cdb_tag == disp_qk);
          nx[fr].vj    = (disp_qj_pend && cdb_valid && cdb_tag == disp_qj) ? cdb_data : disp_vj;
          nx[fr].vk    = (disp_qk_pend && cdb_valid && cdb_tag == disp_qk) ? cdb_data : disp_vk;
        end
        m_ent = nx;
      end
    end
  end

  // monitor: compares flags every cycle and pops the scoreboard on every accepted issue
  exp_t e;
  int   m_free, m_occ;
  always @(negedge clk) begin
    m_free = 0;
    for (int i = 0; i < NE; i++) if (!m_ent[i].valid) m_free++;
    m_occ = NE - m_free;
    check("disp_ready", 64'(disp_ready), 64'(m_free > 0));
    check("issue_valid", 64'(issue_valid), 64'(m_iv));
`ifdef RS_PERF_CNT_EN
    check("perf_occupancy", 64'(perf_occupancy), 64'(m_occ));
`endif
    if (issue_valid && issue_ready && !rst) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 64'(issue_dest), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("issue_op", 64'(issue_op), 64'(e.op));
        check("issue_a", 64'(issue_a), 64'(e.a));
        check("issue_b", 64'(issue_b), 64'(e.b));
        check("issue_dest", 64'(issue_dest), 64'(e.dest));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [3:0] dest, input logic [31:0] vj,
                      input logic [31:0] vk, input logic [3:0] qj, input logic pj,
                      input logic [3:0] qk, input logic pk);
    disp_valid = 1'b1;
    disp_op = op;
    disp_dest = dest;
    disp_vj = vj;
    disp_vk = vk;
    disp_qj = qj;
    disp_qj_pend = pj;
    disp_qk = qk;
    disp_qk_pend = pk;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    disp_valid = 1'b0;
    disp_op = '0; disp_dest = '0; disp_vj = '0; disp_vk = '0;
    disp_qj = '0; disp_qk = '0; disp_qj_pend = 1'b0; disp_qk_pend = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    issue_ready = 1'b1;
    repeat (3) tick();
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_op", 64'(issue_op), 64'd0);
    check("rst_issue_a", 64'(issue_a), 64'd0);
    check("rst_issue_dest", 64'(issue_dest), 64'd0);
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    rst = 1'b0;
    tick();

    // ADD with both operands present
    disp(RSOP_ADD, 4'd3, 32'd5, 32'd7, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    disp_valid = 1'b0;
    check("add_not_yet", 64'(issue_valid), 64'd0);
    check("add_disp_ready", 64'(disp_ready), 64'd1);
    tick();
    check("add_valid", 64'(issue_valid), 64'd1);
    check("add_a", 64'(issue_a), 64'd5);
    check("add_b", 64'(issue_b), 64'd7);
    check("add_dest", 64'(issue_dest), 64'd3);
    tick();

    // SUB waiting on tag 9, woken by a later broadcast
    disp(RSOP_SUB, 4'd1, 32'd0, 32'd1, 4'd9, 1'b1, 4'd0, 1'b0);
    tick();
    disp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h20;
    tick();
    cdb_valid = 1'b0;
    check("sub_wake_not_same", 64'(issue_valid), 64'd0);
    tick();
    check("sub_valid", 64'(issue_valid), 64'd1);
    check("sub_a", 64'(issue_a), 64'h20);
    check("sub_op", 64'(issue_op), 64'(RSOP_SUB));
    tick();

    // same-cycle bypass on k
    disp(RSOP_AND, 4'd2, 32'd3, 32'd0, 4'd0, 1'b0, 4'd2, 1'b1);
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'hAB;
    tick();
    disp_valid = 1'b0;
    cdb_valid = 1'b0;
    tick();
    check("byp_valid", 64'(issue_valid), 64'd1);
    check("byp_b", 64'(issue_b), 64'hAB);
    tick();

    // fill the station with waiting entries, then stall
    for (int i = 0; i < NE; i++) begin
      disp(RSOP_OR, 4'(8 + i), 32'd0, 32'(i), 4'(10 + i), 1'b1, 4'd0, 1'b0);
      tick();
    end
    check("full_disp_ready", 64'(disp_ready), 64'd0);
    disp(RSOP_XOR, 4'd15, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0);
    repeat (3) tick();
    disp_valid = 1'b0;
    check("full_still", 64'(disp_ready), 64'd0);
`ifdef RS_PERF_CNT_EN
    check("perf_stall_3", 64'(perf_stall_cnt), 64'd3);
`endif
    cdb_valid = 1'b1; cdb_tag = 4'd10; cdb_data = 32'h100;
    tick();
    cdb_valid = 1'b0;
    check("full_after_wake", 64'(disp_ready), 64'd0);
    tick();
    check("freed_disp_ready", 64'(disp_ready), 64'd1);
    check("freed_issue_dest", 64'(issue_dest), 64'd8);
    for (int i = 1; i < NE; i++) begin
      cdb_valid = 1'b1; cdb_tag = 4'(10 + i); cdb_data = 32'(i * 16);
      tick();
    end
    cdb_valid = 1'b0;
    repeat (4) tick();

    // backpressure: four ready entries, ALU not accepting
    issue_ready = 1'b0;
    for (int i = 0; i < NE; i++) begin
      disp(RSOP_NOR, 4'(4 + i), 32'(100 + i), 32'(200 + i), 4'd0, 1'b0, 4'd0, 1'b0);
      tick();
    end
    disp_valid = 1'b0;
    check("hold_dest0", 64'(issue_dest), 64'd4);
    check("hold_a0", 64'(issue_a), 64'd100);
    tick();
    check("hold_dest1", 64'(issue_dest), 64'd4);
    check("hold_valid1", 64'(issue_valid), 64'd1);
    issue_ready = 1'b1;
    repeat (6) tick();

    // flush with three entries queued and the issue register full
    issue_ready = 1'b0;
    disp(RSOP_BEQ, 4'd8, 32'd1, 32'd2, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      disp(RSOP_BNE, 4'(9 + i), 32'd0, 32'd0, 4'd15, 1'b1, 4'd0, 1'b0);
      tick();
    end
    disp_valid = 1'b0;
    check("pre_flush_valid", 64'(issue_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_issue_valid", 64'(issue_valid), 64'd0);
    check("flush_disp_ready", 64'(disp_ready), 64'd1);
    issue_ready = 1'b1;
    tick();

    // asynchronous reset between edges
    issue_ready = 1'b0;
    disp(RSOP_SLTU, 4'd12, 32'd9, 32'd10, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    disp_valid = 1'b0;
    tick();
    check("pre_rst_valid", 64'(issue_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(issue_valid), 64'd0);
    check("async_rst_dest", 64'(issue_dest), 64'd0);
    check("async_rst_ready", 64'(disp_ready), 64'd1);
    tick();
    rst = 1'b0;
    tick();

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      disp_valid   = ($urandom_range(0, 3) != 0);
      disp_op      = 5'($urandom);
      disp_dest    = 4'($urandom);
      disp_vj      = $urandom;
      disp_vk      = $urandom;
      disp_qj      = 4'($urandom);
      disp_qk      = 4'($urandom);
      disp_qj_pend = ($urandom_range(0, 2) == 0);
      disp_qk_pend = ($urandom_range(0, 2) == 0);
      cdb_valid    = ($urandom_range(0, 1) == 1);
      cdb_tag      = 4'($urandom);
      cdb_data     = $urandom;
      issue_ready  = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 79) == 0);
      tick();
    end

    // drain: broadcast every tag so nothing stays pending
    disp_valid = 1'b0;
    flush = 1'b0;
    issue_ready = 1'b1;
    for (int c = 0; c < 48; c++) begin
      cdb_valid = 1'b1;
      cdb_tag = 4'(c);
      cdb_data = 32'(c);
      tick();
    end
    cdb_valid = 1'b0;
    repeat (6) tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_issue_valid", 64'(issue_valid), 64'd0);
    check("drain_disp_ready", 64'(disp_ready), 64'd1);
`ifdef RS_PERF_CNT_EN
    check("perf_issue_cnt", 64'(perf_issue_cnt), 64'(m_issue));
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
